// File: rtl/lsu_ctrl.sv
// lsu_ctrl: RV64I load/store unit in front of a 64-bit word memory.
// Ports: req_* pipeline op in, resp_* completion out, mem_* memory pins.
module lsu_ctrl #(
  parameter int XLEN = 64
) (
  input  logic            clk,
  input  logic            rst,
  input  logic            req_valid,
  output logic            req_ready,
  input  logic            req_store,
  input  logic [2:0]      req_funct3,
  input  logic [XLEN-1:0] req_addr,
  input  logic [XLEN-1:0] req_wdata,
  output logic            resp_valid,
  output logic [XLEN-1:0] resp_rdata,
  output logic            resp_err,
  output logic [XLEN-1:0] mem_addr,
  output logic [XLEN-1:0] mem_wdata,
  output logic            mem_read,
  output logic            mem_write,
  input  logic [XLEN-1:0] mem_rdata
);

  typedef enum logic [1:0] {
    IDLE,
    RD_REQ,
    RD_WAIT,
    WR
  } state_t;

  state_t state, state_n;

  logic            st_q;
  logic [2:0]      f3_q;
  logic [2:0]      off_q;
  logic [31:0]     wd_q;
  logic            accept;
  logic            bad_op;
  logic            misal;
  logic            fault;
  logic [5:0]      sh;
  logic [XLEN-1:0] lane;
  logic [XLEN-1:0] ld_val;
  logic [XLEN-1:0] msk;
  logic [XLEN-1:0] ins;
  logic [XLEN-1:0] merged;

  assign req_ready = (state == IDLE);
  assign mem_read  = (state == RD_REQ);
  assign mem_write = (state == WR);
  assign accept    = req_valid && req_ready;
  assign fault     = bad_op || misal;
  assign sh        = {off_q, 3'b000};
  assign lane      = mem_rdata >> sh;

  always_comb begin
    bad_op = req_store ? req_funct3[2]
                       : (req_funct3 == 3'b111);
    unique case (req_funct3[1:0])
      2'b01:   misal = req_addr[0];
      2'b10:   misal = |req_addr[1:0];
      2'b11:   misal = |req_addr[2:0];
      default: misal = 1'b0;
    endcase
  end

  always_comb begin
    ld_val = '0;
    unique case (f3_q)
      3'b000: ld_val = {{56{lane[7]}}, lane[7:0]};
      3'b001: ld_val = {{48{lane[15]}}, lane[15:0]};
      3'b010: ld_val = {{32{lane[31]}}, lane[31:0]};
      3'b011: ld_val = lane;
      3'b100: ld_val = {56'b0, lane[7:0]};
      3'b101: ld_val = {48'b0, lane[15:0]};
      3'b110: ld_val = {32'b0, lane[31:0]};
      default: ld_val = '0;
    endcase
  end

  // Sub-doubleword store: splice the new lane into the old word.
  always_comb begin
    msk = '0;
    unique case (f3_q[1:0])
      2'b00:   msk = 64'h0000_0000_0000_00FF;
      2'b01:   msk = 64'h0000_0000_0000_FFFF;
      default: msk = 64'h0000_0000_FFFF_FFFF;
    endcase
    msk    = msk << sh;
    ins    = {32'b0, wd_q} << sh;
    merged = (mem_rdata & ~msk) | (ins & msk);
  end

  always_comb begin
    state_n = state;
    unique case (state)
      IDLE: begin
        if (accept && !fault) begin
          if (req_store && req_funct3[1:0] == 2'b11)
            state_n = WR;
          else
            state_n = RD_REQ;
        end
      end
      RD_REQ:  state_n = RD_WAIT;
      RD_WAIT: state_n = st_q ? WR : IDLE;
      WR:      state_n = IDLE;
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state      <= IDLE;
      st_q       <= 1'b0;
      f3_q       <= '0;
      off_q      <= '0;
      wd_q       <= '0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= '0;
      mem_addr   <= '0;
      mem_wdata  <= '0;
    end else begin
      state      <= state_n;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      if (accept) begin
        st_q  <= req_store;
        f3_q  <= req_funct3;
        off_q <= req_addr[2:0];
        wd_q  <= req_wdata[31:0];
        if (fault) begin
          resp_valid <= 1'b1;
          resp_err   <= 1'b1;
          resp_rdata <= '0;
        end else begin
          mem_addr <= {req_addr[XLEN-1:3], 3'b000};
          if (req_store)
            mem_wdata <= req_wdata;
        end
      end
      if (state == RD_WAIT) begin
        if (st_q) begin
          mem_wdata <= merged;
        end else begin
          resp_valid <= 1'b1;
          resp_rdata <= ld_val;
        end
      end
      if (state == WR) begin
        resp_valid <= 1'b1;
        resp_rdata <= '0;
      end
    end
  end

endmodule

// File: tb/tb_lsu_ctrl.sv
// tb_lsu_ctrl: scoreboard bench for lsu_ctrl with a word memory model.
// Expected responses are queued at issue and popped on resp_valid.
module tb_lsu_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        req_valid = 1'b0;
  logic        req_store = 1'b0;
  logic [2:0]  req_funct3 = '0;
  logic [63:0] req_addr = '0;
  logic [63:0] req_wdata = '0;
  logic        req_ready;
  logic        resp_valid;
  logic [63:0] resp_rdata;
  logic        resp_err;
  logic [63:0] mem_addr;
  logic [63:0] mem_wdata;
  logic        mem_read;
  logic        mem_write;
  logic [63:0] mem_rdata;

  always #5 clk = ~clk;

  lsu_ctrl dut (
    .clk        (clk),
    .rst        (rst),
    .req_valid  (req_valid),
    .req_ready  (req_ready),
    .req_store  (req_store),
    .req_funct3 (req_funct3),
    .req_addr   (req_addr),
    .req_wdata  (req_wdata),
    .resp_valid (resp_valid),
    .resp_rdata (resp_rdata),
    .resp_err   (resp_err),
    .mem_addr   (mem_addr),
    .mem_wdata  (mem_wdata),
    .mem_read   (mem_read),
    .mem_write  (mem_write),
    .mem_rdata  (mem_rdata)
  );

  typedef struct {
    string       nm;
    logic [63:0] rd;
    logic        err;
    int          acc;
    int          lat;
  } exp_t;

  exp_t q[$];
  exp_t ex;

  int n_run = 0;
  int n_fail = 0;
  int cyc = 0;
  int nrd = 0;
  int nwr = 0;
  int nresp = 0;

  logic [63:0] rd_addr = '0;
  logic [63:0] wr_addr = '0;
  logic [63:0] wr_data = '0;
  logic [63:0] mem [0:31];
  logic        pl_en = 1'b0;
  logic [4:0]  pl_idx = '0;
  logic [63:0] pl_dat = '0;

  task automatic chk(input string tag, input logic [63:0] got,
                     input logic [63:0] exp);
    n_run++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    cyc <= cyc + 1;
    if (pl_en)
      mem[pl_idx] <= pl_dat;
    if (mem_read) begin
      mem_rdata <= mem[mem_addr[7:3]];
      nrd       <= nrd + 1;
      rd_addr   <= mem_addr;
    end
    if (mem_write) begin
      mem[mem_addr[7:3]] <= mem_wdata;
      nwr     <= nwr + 1;
      wr_addr <= mem_addr;
      wr_data <= mem_wdata;
    end
  end

  always @(negedge clk) begin
    if (resp_valid) begin
      nresp++;
      if (q.size() == 0) begin
        chk("unexpected_resp", 64'd1, 64'd0);
      end else begin
        ex = q.pop_front();
        chk(ex.nm, resp_rdata, ex.rd);
        chk({ex.nm, "_err"}, 64'(resp_err), 64'(ex.err));
        chk({ex.nm, "_lat"}, 64'(cyc - ex.acc + 1), 64'(ex.lat));
      end
    end
  end

  task automatic issue(input string nm, input logic s, input logic [2:0] f,
                       input logic [63:0] a, input logic [63:0] w,
                       input logic [63:0] rd, input logic er,
                       input int lat, input bit hold);
    exp_t e;
    int   k;
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = s;
    req_funct3 = f;
    req_addr   = a;
    req_wdata  = w;
    k = 0;
    while (!req_ready && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (!req_ready) begin
      chk({nm, "_accept_timeout"}, 64'd0, 64'd1);
      req_valid = 1'b0;
      return;
    end
    e.nm  = nm;
    e.rd  = rd;
    e.err = er;
    e.acc = cyc + 1;
    e.lat = lat;
    q.push_back(e);
    @(posedge clk);
    if (!hold) begin
      #1 req_valid = 1'b0;
    end
  endtask

  task automatic wait_done();
    int k;
    k = 0;
    while (q.size() != 0 && k < 40) begin
      @(negedge clk);
      k++;
    end
    if (q.size() != 0) begin
      chk("resp_timeout", 64'(q.size()), 64'd0);
      q.delete();
    end
    @(negedge clk);
  endtask

  localparam logic [63:0] W0 = 64'h8877665544332211;
  localparam logic [63:0] W1 = 64'h88776655ABCD2211;
  localparam logic [63:0] D0 = 64'h0123456789ABCDEF;

  logic [63:0] wv;
  logic [7:0]  b;
  int          s_rd, s_wr, s_rs;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    repeat (2) @(negedge clk);
    chk("rst_ready", 64'(req_ready), 64'd1);
    chk("rst_resp_valid", 64'(resp_valid), 64'd0);
    chk("rst_resp_err", 64'(resp_err), 64'd0);
    chk("rst_resp_rdata", resp_rdata, 64'd0);
    chk("rst_mem_read", 64'(mem_read), 64'd0);
    chk("rst_mem_write", 64'(mem_write), 64'd0);
    chk("rst_mem_addr", mem_addr, 64'd0);
    chk("rst_mem_wdata", mem_wdata, 64'd0);

    pl_en  = 1'b1;
    pl_idx = 5'd2;
    pl_dat = W0;
    rst    = 1'b1;
    @(negedge clk);
    pl_en = 1'b0;

    s_rd = nrd;
    issue("lb_17", 1'b0, 3'b000, 64'h17, 64'd0,
          64'hFFFFFFFFFFFFFF88, 1'b0, 3, 1'b0);
    wait_done();
    chk("lb_nrd", 64'(nrd - s_rd), 64'd1);
    chk("lb_rd_addr", rd_addr, 64'h10);

    issue("lbu_17", 1'b0, 3'b100, 64'h17, 64'd0,
          64'h0000000000000088, 1'b0, 3, 1'b0);
    issue("lw_14", 1'b0, 3'b010, 64'h14, 64'd0,
          64'hFFFFFFFF88776655, 1'b0, 3, 1'b0);
    issue("lwu_14", 1'b0, 3'b110, 64'h14, 64'd0,
          64'h0000000088776655, 1'b0, 3, 1'b0);
    issue("ld_10", 1'b0, 3'b011, 64'h10, 64'd0, W0, 1'b0, 3, 1'b0);
    wait_done();

    s_rd = nrd;
    s_wr = nwr;
    issue("sh_12", 1'b1, 3'b001, 64'h12, 64'h000000000000ABCD,
          64'd0, 1'b0, 4, 1'b0);
    wait_done();
    chk("sh_nrd", 64'(nrd - s_rd), 64'd1);
    chk("sh_nwr", 64'(nwr - s_wr), 64'd1);
    chk("sh_wr_addr", wr_addr, 64'h10);
    chk("sh_wr_data", wr_data, W1);
    issue("ld_sh", 1'b0, 3'b011, 64'h10, 64'd0, W1, 1'b0, 3, 1'b0);
    wait_done();

    s_rd = nrd;
    s_wr = nwr;
    issue("sd_18", 1'b1, 3'b011, 64'h18, D0, 64'd0, 1'b0, 2, 1'b0);
    wait_done();
    chk("sd_nrd", 64'(nrd - s_rd), 64'd0);
    chk("sd_nwr", 64'(nwr - s_wr), 64'd1);
    chk("sd_wr_data", wr_data, D0);
    issue("ld_sd", 1'b0, 3'b011, 64'h18, 64'd0, D0, 1'b0, 3, 1'b0);
    wait_done();

    s_rd = nrd;
    s_wr = nwr;
    issue("e_lw_12", 1'b0, 3'b010, 64'h12, 64'd0, 64'd0, 1'b1, 1, 1'b0);
    issue("e_sh_13", 1'b1, 3'b001, 64'h13, 64'd0, 64'd0, 1'b1, 1, 1'b0);
    issue("e_ld111", 1'b0, 3'b111, 64'h10, 64'd0, 64'd0, 1'b1, 1, 1'b0);
    issue("e_sd_14", 1'b1, 3'b011, 64'h14, 64'd0, 64'd0, 1'b1, 1, 1'b0);
    issue("e_st100", 1'b1, 3'b100, 64'h10, 64'd0, 64'd0, 1'b1, 1, 1'b0);
    issue("e_lh_11", 1'b0, 3'b001, 64'h11, 64'd0, 64'd0, 1'b1, 1, 1'b0);
    wait_done();
    chk("err_nrd", 64'(nrd - s_rd), 64'd0);
    chk("err_nwr", 64'(nwr - s_wr), 64'd0);

    wv = W1;
    for (int o = 0; o < 8; o++) begin
      b = wv[8*o +: 8];
      issue("lbu_lane", 1'b0, 3'b100, 64'h10 + 64'(o), 64'd0,
            {56'b0, b}, 1'b0, 3, 1'b0);
      issue("lb_lane", 1'b0, 3'b000, 64'h10 + 64'(o), 64'd0,
            {{56{b[7]}}, b}, 1'b0, 3, 1'b0);
    end
    wait_done();

    s_wr = nwr;
    s_rs = nresp;
    @(negedge clk);
    req_valid  = 1'b1;
    req_store  = 1'b1;
    req_funct3 = 3'b000;
    req_addr   = 64'h10;
    req_wdata  = 64'hFF;
    @(posedge clk);
    #1 req_valid = 1'b0;
    @(negedge clk);
    chk("rmw_rd_req", 64'(mem_read), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    #1;
    chk("mid_rst_ready", 64'(req_ready), 64'd1);
    chk("mid_rst_mem_read", 64'(mem_read), 64'd0);
    chk("mid_rst_mem_write", 64'(mem_write), 64'd0);
    chk("mid_rst_resp", 64'(resp_valid), 64'd0);
    @(negedge clk);
    rst = 1'b1;
    repeat (4) @(negedge clk);
    chk("mid_rst_nwr", 64'(nwr - s_wr), 64'd0);
    chk("mid_rst_nresp", 64'(nresp - s_rs), 64'd0);
    issue("ld_after_rst", 1'b0, 3'b011, 64'h10, 64'd0, W1, 1'b0, 3, 1'b0);
    wait_done();

    s_rd = nrd;
    s_rs = nresp;
    issue("b2b_ld", 1'b0, 3'b011, 64'h18, 64'd0, D0, 1'b0, 3, 1'b1);
    issue("b2b_sw", 1'b1, 3'b010, 64'h1C, 64'h00000000DEADBEEF,
          64'd0, 1'b0, 4, 1'b1);
    issue("b2b_err", 1'b0, 3'b011, 64'h19, 64'd0, 64'd0, 1'b1, 1, 1'b1);
    issue("b2b_lwu", 1'b0, 3'b110, 64'h1C, 64'd0,
          64'h00000000DEADBEEF, 1'b0, 3, 1'b1);
    issue("b2b_lh", 1'b0, 3'b001, 64'h1E, 64'd0,
          64'hFFFFFFFFFFFFDEAD, 1'b0, 3, 1'b0);
    wait_done();
    repeat (3) @(negedge clk);
    chk("b2b_nresp", 64'(nresp - s_rs), 64'd5);
    chk("b2b_nrd", 64'(nrd - s_rd), 64'd4);
    issue("ld_b2b", 1'b0, 3'b011, 64'h18, 64'd0,
          64'hDEADBEEF89ABCDEF, 1'b0, 3, 1'b0);
    wait_done();

    $display("[TB] %0d tests run, %0d failed", n_run, n_fail);
    $finish;
  end

endmodule

// File: doc/lsu_ctrl.md
Name: lsu_ctrl

Overview:
- Load/store unit between the MEM pipeline stage and the 64-bit word-organised data memory.
- Converts RV64I byte, half, word and double loads/stores into aligned 64-bit memory accesses:
  - loads: lane extraction with sign/zero extension;
  - sub-doubleword stores: read-modify-write.
- Flags misaligned or illegal accesses without touching memory.
- Drives the memory's mem_read/mem_write/address/write_data pins; consumes its registered read_data (one-cycle read latency).

Parameters:
- XLEN, 64, datapath and address width (fixed at 64 for RV64I; no other value supported).

Ports:
- clk  input  1  system clock
- rst  input  1  reset, asynchronous, active-low
- req_valid  input  1  pipeline presents a memory op
- req_ready  output  1  unit idle, accepts op this cycle
- req_store  input  1  1 = store, 0 = load
- req_funct3  input  3  RV64I funct3 (size/sign)
- req_addr  input  64  byte address
- req_wdata  input  64  store data, right-aligned
- resp_valid  output  1  one-cycle completion pulse
- resp_rdata  output  64  extended load result (0 for stores/errors)
- resp_err  output  1  misaligned/illegal, qualified by resp_valid
- mem_addr  output  64  {addr[63:3],3'b000}
- mem_wdata  output  64  doubleword to write
- mem_read  output  1  memory read enable
- mem_write  output  1  memory write enable
- mem_rdata  input  64  memory read data, valid the cycle after mem_read

Behaviour:
- Interface: clock is clk; reset is asynchronous and active-low (rst).
- Reset values:
  - state IDLE, req_ready=1;
  - resp_valid=0, resp_err=0, resp_rdata=0;
  - mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
- FSM states: IDLE, RD_REQ, RD_WAIT, WR. mem_read=1 only in RD_REQ; mem_write=1 only in WR (Moore outputs). req_ready=(state==IDLE).
- Accept: req_valid&&req_ready at a rising edge. Latch store, funct3, addr, wdata. req_valid in non-IDLE states is ignored; requester holds.
- Legality:
  - load funct3 111 is illegal; store funct3[2]=1 is illegal.
  - Misaligned: half addr[0]!=0; word addr[1:0]!=0; double addr[2:0]!=0.
  - Illegal or misaligned op: stay IDLE; next cycle resp_valid=1, resp_err=1, resp_rdata=0. No mem_read/mem_write ever.
- Load, legal: IDLE->RD_REQ->RD_WAIT->IDLE.
  - In RD_WAIT: extract lane at byte offset addr[2:0] (little-endian, byte k = bits 8k+7:8k).
  - Sign-extend for 000/001/010; zero-extend for 100/101/110; 011 passes all 64 bits.
  - Register into resp_rdata; resp_valid=1 the cycle after RD_WAIT.
  - Latency: accept edge -> resp_valid 3 cycles later.
- SD (011): IDLE->WR. mem_wdata=req_wdata; resp_valid 2 cycles after accept.
- SB/SH/SW: IDLE->RD_REQ->RD_WAIT->WR.
  - In RD_WAIT: merge the low 8/16/32 bits of wdata into mem_rdata at offset addr[2:0]; other bytes unchanged. Register the result to mem_wdata.
  - resp_valid 4 cycles after accept.
- Store response: resp_rdata=0, resp_err=0.
- mem_addr is held stable for the whole transaction.
- resp_valid is a single-cycle pulse. A new request may be accepted in the same cycle resp_valid is high.
- Reset mid-operation: immediately return to IDLE and deassert mem_read/mem_write; the pending op is dropped with no resp. An RMW reset before WR leaves memory unchanged.
- Address bits above memory depth are passed through unchecked.

Test Plan:
- Preload mem[0x10]=0x8877665544332211; LB addr 0x17 -> mem_read one cycle with mem_addr 0x10; resp_rdata=0xFFFFFFFFFFFFFF88, resp_valid 3 cycles after accept.
- Same word: LBU 0x17 -> 0x0000000000000088; LW 0x14 -> 0xFFFFFFFF88776655; LWU 0x14 -> 0x0000000088776655; LD 0x10 -> 0x8877665544332211.
- SH addr 0x12, wdata 0x000000000000ABCD -> read, then single write 0x88776655ABCD2211 to mem_addr 0x10; resp_valid 4 cycles after accept; LD 0x10 returns the merged value.
- SD addr 0x18, wdata 0x0123456789ABCDEF -> no mem_read, one mem_write; resp 2 cycles after accept; LD readback matches.
- LW addr 0x12; SH addr 0x13; load funct3 111 -> resp_err=1, resp_rdata=0 the next cycle, mem_read=mem_write=0 throughout.
- SB addr 0x10 wdata 0xFF, rst low during RD_WAIT -> no mem_write, no resp_valid, req_ready=1; mem[0x10] unchanged. Back-to-back requests with req_valid held while busy are each accepted exactly once.
